sha256_digest_serializer: RTL and testbench

- Downstream stage of the SHA-256 top level.
- Captures the 256-bit digest when the controller asserts done.
- Streams the digest out as 256/OUT_W words, most-significant word first (H0 first), over a valid/ready handshake.
- Decouples the hash core from a narrow, back-pressuring consumer such as a bus-interface FIFO or UART bridge.

---
 rtl/sha256_digest_serializer.sv | 144 ++++++++++++++
 tb/tb_sha256_digest_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_digest_serializer.sv
// sha256_digest_serializer
// Captures a 256-bit SHA-256 digest on done_i. Streams it out as BEATS
// words of OUT_W bits, H0 first, over a valid/ready handshake.
// Optional feature macro: SER_PEND_EN adds a one-entry pending digest
// register, so a digest that arrives mid-stream is queued, not dropped.
module sha256_digest_serializer #(
  parameter int OUT_W = 32,
  parameter int BEATS = 256 / OUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     done_i,
  input  logic [255:0]             hash_i,
  output logic [OUT_W-1:0]         dout_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic                     dout_last_o,
  output logic [$clog2(BEATS)-1:0] beat_o,
  output logic                     busy_o,
  output logic                     drop_o
);

  localparam int BW = $clog2(BEATS);

  generate
    if (OUT_W != 32 && OUT_W != 64 && OUT_W != 128) begin : g_bad_out_w
      $fatal(1, "sha256_digest_serializer: OUT_W must be 32, 64 or 128");
    end
    if (BEATS != 256 / OUT_W) begin : g_bad_beats
      $fatal(1, "sha256_digest_serializer: BEATS must equal 256/OUT_W");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [255:0]    shift_reg, shift_next;
  logic [BW-1:0]   beat, beat_next;
  logic            drop_next;
  logic            xfer, final_xfer;

`ifdef SER_PEND_EN
  logic [255:0]    pend_reg, pend_next;
  logic            pend_valid, pend_valid_next;
`endif

  // The output word is always the top slice of the shift register; outputs are forced to zero while idle.
  assign busy_o       = (state == SEND);
  assign dout_valid_o = busy_o;
  assign dout_o       = busy_o ? shift_reg[255 -: OUT_W] : '0;
  assign beat_o       = busy_o ? beat : '0;
  assign dout_last_o  = busy_o && (beat == BW'(BEATS - 1));
  assign xfer         = dout_valid_o && dout_ready_i;
  assign final_xfer   = xfer && dout_last_o;

  // Next-state logic: load, shift, reload on the final beat, and decide whether an incoming digest is kept or dropped.
  always_comb begin
    state_next      = state;
    shift_next      = shift_reg;
    beat_next       = beat;
    drop_next       = 1'b0;
`ifdef SER_PEND_EN
    pend_next       = pend_reg;
    pend_valid_next = pend_valid;
`endif
    case (state)
      IDLE: begin
        if (done_i) begin
          shift_next = hash_i;
          beat_next  = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (final_xfer) begin
          beat_next = '0;
`ifdef SER_PEND_EN
          if (pend_valid) begin
            shift_next      = pend_reg;
            pend_valid_next = done_i;
            if (done_i) begin
              pend_next = hash_i;
            end
          end else if (done_i) begin
            shift_next = hash_i;
          end else begin
            state_next = IDLE;
          end
`else
          if (done_i) begin
            shift_next = hash_i;
          end else begin
            state_next = IDLE;
          end
`endif
        end else begin
          if (xfer) begin
            shift_next = {shift_reg[255-OUT_W:0], {OUT_W{1'b0}}};
            beat_next  = beat + BW'(1);
          end
          if (done_i) begin
`ifdef SER_PEND_EN
            if (!pend_valid) begin
              pend_next       = hash_i;
              pend_valid_next = 1'b1;
            end else begin
              drop_next = 1'b1;
            end
`else
            drop_next = 1'b1;
`endif
          end
        end
      end
    endcase
  end

  // State register with asynchronous active-low reset; reset abandons any partially sent digest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      beat       <= '0;
      drop_o     <= 1'b0;
`ifdef SER_PEND_EN
      pend_reg   <= '0;
      pend_valid <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      beat       <= beat_next;
      drop_o     <= drop_next;
`ifdef SER_PEND_EN
      pend_reg   <= pend_next;
      pend_valid <= pend_valid_next;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Self-checking bench for sha256_digest_serializer (OUT_W = 32).
// The reference model is a queue of expected output words. A digest is
// accepted if the queue will hold no more than CAP-1 digests after this
// cycle's transfer. Otherwise it is dropped.
module tb_sha256_digest_serializer;

  localparam int OUT_W = 32;
  localparam int BEATS = 256 / OUT_W;
  localparam int BW    = $clog2(BEATS);
`ifdef SER_PEND_EN
  localparam int CAP   = 2;
`else
  localparam int CAP   = 1;
`endif

  localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic             clk;
  logic             rst_n;
  logic             done_i;
  logic [255:0]     hash_i;
  logic [OUT_W-1:0] dout_o;
  logic             dout_valid_o;
  logic             dout_ready_i;
  logic             dout_last_o;
  logic [BW-1:0]    beat_o;
  logic             busy_o;
  logic             drop_o;

  logic [OUT_W-1:0] exp_words[$];
  int               exp_beats[$];
  logic             exp_drop;
  int               checks;
  int               errors;
  logic [31:0]      abc_words [8];

  sha256_digest_serializer #(.OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .done_i       (done_i),
    .hash_i       (hash_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_last_o  (dout_last_o),
    .beat_o       (beat_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against the model state for the current cycle.
  task automatic checkCycle();
    logic has_word;
    has_word = (exp_words.size() > 0);
    checkOutput("valid", dout_valid_o, has_word);
    checkOutput("busy", busy_o, has_word);
    checkOutput("drop", drop_o, exp_drop);
    if (has_word) begin
      checkOutput("dout", dout_o, exp_words[0]);
      checkOutput("beat", beat_o, exp_beats[0]);
      checkOutput("last", dout_last_o, exp_beats[0] == BEATS - 1);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge, then check at the falling edge.
  task automatic applyStimulus(input logic done, input logic [255:0] hash, input logic ready);
    logic xfer;
    done_i       = done;
    hash_i       = hash;
    dout_ready_i = ready;
    xfer = (exp_words.size() > 0) && ready;
    @(posedge clk);
    if (xfer) begin
      void'(exp_words.pop_front());
      void'(exp_beats.pop_front());
    end
    exp_drop = 1'b0;
    if (done) begin
      if (exp_words.size() <= (CAP - 1) * BEATS) begin
        for (int i = 0; i < BEATS; i++) begin
          exp_words.push_back(hash[255 - i*OUT_W -: OUT_W]);
          exp_beats.push_back(i);
        end
      end else begin
        exp_drop = 1'b1;
      end
    end
    @(negedge clk);
    checkCycle();
  endtask

  // Run cycles with ready=1 and no new digests until the model is empty, within a cycle budget.
  task automatic drain();
    int n;
    n = 0;
    while (exp_words.size() > 0 && n < 100) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_done", exp_words.size() == 0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  function automatic logic [255:0] randomDigest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    int stalls;
    int cycles;
    checks       = 0;
    errors       = 0;
    exp_drop     = 1'b0;
    abc_words    = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                     32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    rst_n        = 1'b0;
    done_i       = 1'b0;
    hash_i       = '0;
    dout_ready_i = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_valid", dout_valid_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_beat", beat_o, 0);
    checkOutput("rst_last", dout_last_o, 1'b0);
    checkOutput("rst_dout", dout_o, 0);
    checkOutput("rst_drop", drop_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);

    // "abc" digest with ready held high: eight consecutive beats.
    $display("[TB] abc digest, ready high");
    applyStimulus(1'b1, ABC_DIGEST, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("abc_word", dout_o, abc_words[i]);
      checkOutput("abc_beat", beat_o, i);
      checkOutput("abc_last", dout_last_o, i == 7);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("abc_valid_drop", dout_valid_o, 1'b0);

    // Same digest with ready toggling 1,0,0,1,0,0...
    $display("[TB] abc digest, stalled consumer");
    applyStimulus(1'b1, ABC_DIGEST, 1'b1);
    stalls = 0;
    cycles = 0;
    while (exp_words.size() > 0 && cycles < 100) begin
      if (cycles % 3 != 0) stalls++;
      applyStimulus(1'b0, '0, (cycles % 3) == 0);
      cycles++;
    end
    checkOutput("stall_cycles", cycles, 8 + stalls);

    // Back-to-back digests: the second arrives on the final transfer of the first.
    $display("[TB] back-to-back digests");
    applyStimulus(1'b1, ABC_DIGEST, 1'b1);
    repeat (7) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b2b_last_word", dout_o, 32'hf20015ad);
    applyStimulus(1'b1, EMPTY_DIGEST, 1'b1);
    checkOutput("b2b_next_word", dout_o, 32'he3b0c442);
    checkOutput("b2b_no_gap", dout_valid_o, 1'b1);
    checkOutput("b2b_no_drop", drop_o, 1'b0);
    drain();

    // Digest arriving mid-stream at beat 3, followed by a third in the same window.
    $display("[TB] mid-stream digest arrivals");
    applyStimulus(1'b1, ABC_DIGEST, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_beat3", beat_o, 3);
    applyStimulus(1'b1, EMPTY_DIGEST, 1'b1);
`ifdef SER_PEND_EN
    checkOutput("mid_second_kept", drop_o, 1'b0);
`else
    checkOutput("mid_second_drop", drop_o, 1'b1);
`endif
    applyStimulus(1'b1, randomDigest(), 1'b0);
    checkOutput("mid_third_drop", drop_o, 1'b1);
    drain();

    // Asynchronous reset at beat 5.
    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, ABC_DIGEST, 1'b1);
    repeat (5) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pre_rst_beat5", beat_o, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", dout_valid_o, 1'b0);
    checkOutput("arst_busy", busy_o, 1'b0);
    checkOutput("arst_beat", beat_o, 0);
    checkOutput("arst_last", dout_last_o, 1'b0);
    exp_words.delete();
    exp_beats.delete();
    exp_drop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, EMPTY_DIGEST, 1'b1);
    checkOutput("post_rst_word", dout_o, 32'he3b0c442);
    drain();

    // Randomized traffic against the queue model.
    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, randomDigest(), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
